// File: rtl/jelly2_mipi_csi2_rx_packet_ctl_if.sv
// ---------------------------------------------------------------------------
// jelly2_mipi_csi2_rx_packet_ctl_if
//   Byte-wide AXI4-Stream style bundle used on both sides of the CSI-2 packet
//   sequencer.
//
//   Signals:
//     tuser  : sideband marker (first DI byte on the input side, frame start
//              on the output side)
//     tlast  : end of line (driven on the output side only)
//     tdata  : 8-bit byte
//     tvalid : byte valid
//     tready : byte accepted by the sink
//
//   Modports:
//     master : drives tuser/tlast/tdata/tvalid, receives tready
//     slave  : receives tuser/tlast/tdata/tvalid, drives tready
// ---------------------------------------------------------------------------
interface jelly2_mipi_csi2_rx_packet_ctl_if;
  logic       tuser;
  logic       tlast;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tuser, output tlast, output tdata, output tvalid, input  tready);
  modport slave  (input  tuser, input  tlast, input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/jelly2_mipi_csi2_rx_packet_ctl.sv
// ---------------------------------------------------------------------------
// jelly2_mipi_csi2_rx_packet_ctl
//   Packet-level sequencer between the lane-merged CSI-2 byte stream and the
//   RAW10 unpacker. Parses packet headers, reports FS/FE short packets and
//   forwards only the payload of long packets whose VC/DT match the selection,
//   framed with tuser (first byte after FS) and tlast (last byte of the line).
//
//   Ports:
//     aresetn         : asynchronous active-low reset
//     aclk            : clock
//     param_data_type : data type to forward
//     param_vc        : virtual channel to forward
//     s_axi4s         : input byte stream (slave); tuser marks the DI byte,
//                       tlast is not used
//     m_axi4s         : payload output (master), one register stage
//     frame_start     : one-cycle pulse on FS with matching VC
//     frame_end       : one-cycle pulse on FE with matching VC
//     err_sync        : one-cycle pulse on an unexpected tuser (or on a bad
//                       WC when the WC check is enabled)
//
//   Build option:
//     JELLY2_MIPI_CSI2_RX_CTL_WC_CHECK_EN : when defined, a matching long
//       packet whose WC is not a multiple of 5 is discarded and flagged on
//       err_sync.
// ---------------------------------------------------------------------------
module jelly2_mipi_csi2_rx_packet_ctl #(
  parameter logic [5:0] DEFAULT_DT = 6'h2b,
  parameter logic [1:0] DEFAULT_VC = 2'd0
) (
  input  logic                                   aresetn,
  input  logic                                   aclk,
  input  logic [5:0]                             param_data_type,
  input  logic [1:0]                             param_vc,
  jelly2_mipi_csi2_rx_packet_ctl_if.slave        s_axi4s,
  jelly2_mipi_csi2_rx_packet_ctl_if.master       m_axi4s,
  output logic                                   frame_start,
  output logic                                   frame_end,
  output logic                                   err_sync
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_PAYLOAD,
    ST_DISCARD,
    ST_CRC
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] remain_q, remain_d;
  logic        fs_pend_q, fs_pend_d;
  logic        crc_cnt_q, crc_cnt_d;

  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tuser_q, m_tuser_d;
  logic        m_tlast_q, m_tlast_d;
  logic [7:0]  m_tdata_q, m_tdata_d;

  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        err_sync_q, err_sync_d;

  // Selection registers: the parameters are quasi-static, so they are
  // registered to keep the header compare off the external input path.
  logic [5:0]  sel_dt_q;
  logic [1:0]  sel_vc_q;

  logic        s_ready;
  logic        s_fire;
  logic        wc_bad;
  logic        hdr_match;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;

  // Only the payload state can stall the input; everything else is dropped.
  assign s_ready = (state_q != ST_PAYLOAD) || !m_tvalid_q || m_axi4s.tready;
  assign s_fire  = s_axi4s.tvalid && s_ready;

  assign hdr_dt    = di_q[5:0];
  assign hdr_vc    = di_q[7:6];
  assign hdr_match = (hdr_vc == sel_vc_q) && (hdr_dt == sel_dt_q);

`ifdef JELLY2_MIPI_CSI2_RX_CTL_WC_CHECK_EN
  // RAW10 lines must be made of whole 5-byte groups.
  assign wc_bad = (wc_q % 16'd5) != 16'd0;
`else
  assign wc_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    di_d          = di_q;
    wc_d          = wc_q;
    remain_d      = remain_q;
    fs_pend_d     = fs_pend_q;
    crc_cnt_d     = crc_cnt_q;
    m_tvalid_d    = m_tvalid_q;
    m_tuser_d     = m_tuser_q;
    m_tlast_d     = m_tlast_q;
    m_tdata_d     = m_tdata_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    err_sync_d    = 1'b0;

    // Output register drains; a new payload byte below takes priority.
    if (m_tvalid_q && m_axi4s.tready) begin
      m_tvalid_d = 1'b0;
    end

    if (s_fire) begin
      if (s_axi4s.tuser) begin
        // Any tuser byte starts a new header. Outside IDLE it means the
        // previous packet was cut short; its line is left without tlast.
        di_d       = s_axi4s.tdata;
        state_d    = ST_HDR1;
        err_sync_d = (state_q != ST_IDLE);
      end else begin
        case (state_q)
          ST_IDLE: begin
            // inter-packet filler, dropped
          end
          ST_HDR1: begin
            wc_d[7:0] = s_axi4s.tdata;
            state_d   = ST_HDR2;
          end
          ST_HDR2: begin
            wc_d[15:8] = s_axi4s.tdata;
            state_d    = ST_HDR3;
          end
          ST_HDR3: begin
            // ECC byte itself is ignored; the header decision happens here.
            if (hdr_dt < 6'h10) begin
              if (hdr_vc == sel_vc_q) begin
                if (hdr_dt == 6'h00) begin
                  frame_start_d = 1'b1;
                  fs_pend_d     = 1'b1;
                end
                if (hdr_dt == 6'h01) begin
                  frame_end_d = 1'b1;
                end
              end
              state_d = ST_IDLE;
            end else if (wc_q == 16'd0) begin
              crc_cnt_d = 1'b0;
              state_d   = ST_CRC;
            end else if (hdr_match && !wc_bad) begin
              remain_d = wc_q;
              state_d  = ST_PAYLOAD;
            end else begin
              remain_d   = wc_q;
              state_d    = ST_DISCARD;
              err_sync_d = hdr_match && wc_bad;
            end
          end
          ST_PAYLOAD: begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axi4s.tdata;
            m_tuser_d  = fs_pend_q;
            m_tlast_d  = (remain_q == 16'd1);
            fs_pend_d  = 1'b0;
            remain_d   = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              crc_cnt_d = 1'b0;
              state_d   = ST_CRC;
            end
          end
          ST_DISCARD: begin
            remain_d = remain_q - 16'd1;
            if (remain_q == 16'd1) begin
              crc_cnt_d = 1'b0;
              state_d   = ST_CRC;
            end
          end
          ST_CRC: begin
            if (crc_cnt_q) begin
              crc_cnt_d = 1'b0;
              state_d   = ST_IDLE;
            end else begin
              crc_cnt_d = 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      di_q          <= 8'h00;
      wc_q          <= 16'h0000;
      remain_q      <= 16'h0000;
      fs_pend_q     <= 1'b0;
      crc_cnt_q     <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tuser_q     <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= 8'h00;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      err_sync_q    <= 1'b0;
      sel_dt_q      <= DEFAULT_DT;
      sel_vc_q      <= DEFAULT_VC;
    end else begin
      state_q       <= state_d;
      di_q          <= di_d;
      wc_q          <= wc_d;
      remain_q      <= remain_d;
      fs_pend_q     <= fs_pend_d;
      crc_cnt_q     <= crc_cnt_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tuser_q     <= m_tuser_d;
      m_tlast_q     <= m_tlast_d;
      m_tdata_q     <= m_tdata_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      err_sync_q    <= err_sync_d;
      sel_dt_q      <= param_data_type;
      sel_vc_q      <= param_vc;
    end
  end

  assign s_axi4s.tready = s_ready;
  assign m_axi4s.tvalid = m_tvalid_q;
  assign m_axi4s.tuser  = m_tuser_q;
  assign m_axi4s.tlast  = m_tlast_q;
  assign m_axi4s.tdata  = m_tdata_q;
  assign frame_start    = frame_start_q;
  assign frame_end      = frame_end_q;
  assign err_sync       = err_sync_q;

endmodule

// File: tb/tb_jelly2_mipi_csi2_rx_packet_ctl.sv
module tb_jelly2_mipi_csi2_rx_packet_ctl;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [5:0] param_data_type = 6'h2b;
  logic [1:0] param_vc = 2'd0;
  logic       frame_start;
  logic       frame_end;
  logic       err_sync;

  jelly2_mipi_csi2_rx_packet_ctl_if s_if ();
  jelly2_mipi_csi2_rx_packet_ctl_if m_if ();

  jelly2_mipi_csi2_rx_packet_ctl #(
    .DEFAULT_DT (6'h2b),
    .DEFAULT_VC (2'd0)
  ) dut (
    .aresetn         (aresetn),
    .aclk            (aclk),
    .param_data_type (param_data_type),
    .param_vc        (param_vc),
    .s_axi4s         (s_if),
    .m_axi4s         (m_if),
    .frame_start     (frame_start),
    .frame_end       (frame_end),
    .err_sync        (err_sync)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic       u;
    logic       l;
    logic [7:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    fs_cnt = 0;
  int    fe_cnt = 0;
  int    err_cnt = 0;
  int    out_cnt = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random 50%, 2: never ready
  logic  fs_pend_m = 1'b0; // bench model of the pending frame-start flag

  // Scoreboard: pop an expected beat on every output transfer, and check
  // that a stalled output holds its value.
  task automatic monitor();
    beat_t held;
    beat_t got;
    beat_t e;
    logic  stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        got = {m_if.tuser, m_if.tlast, m_if.tdata};
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (err_sync) err_cnt++;
        if (stalled) begin
          n_chk++;
          if (m_if.tvalid !== 1'b1 || got !== held)
            $display("FAIL stall_hold: got v=%b %h, required v=1 %h", m_if.tvalid, got, held);
          else
            n_pass++;
        end
        if (m_if.tvalid && m_if.tready) begin
          out_cnt++;
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: got %h, required no output", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e)
              $display("FAIL beat_%0d: got u=%b l=%b d=%h, required u=%b l=%b d=%h",
                       out_cnt, got.u, got.l, got.d, e.u, e.l, e.d);
            else
              n_pass++;
          end
        end
        stalled = m_if.tvalid && !m_if.tready;
        held    = got;
      end
    end
  endtask

  task automatic ready_gen();
    forever begin
      @(posedge aclk);
      #1;
      case (ready_mode)
        1:       m_if.tready = ($urandom_range(0, 1) == 1);
        2:       m_if.tready = 1'b0;
        default: m_if.tready = 1'b1;
      endcase
    end
  endtask

  task automatic send_byte(input logic u, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge aclk);
    s_if.tuser  = u;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && t < 5000) begin
      @(negedge aclk);
      t++;
    end
    if (!s_if.tready) begin
      n_chk++;
      $display("FAIL s_tready_timeout: got 0 after %0d cycles, required 1", t);
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
    send_byte(1'b1, {vc, dt});
    send_byte(1'b0, wc[7:0]);
    send_byte(1'b0, wc[15:8]);
    send_byte(1'b0, 8'h3c);
  endtask

  task automatic send_short(input logic [1:0] vc, input logic [5:0] dt);
    send_hdr(vc, dt, 16'h1234);
    if (dt == 6'h00 && vc == param_vc) fs_pend_m = 1'b1;
  endtask

  task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input int wc, input logic fwd);
    logic [7:0] d;
    send_hdr(vc, dt, wc[15:0]);
    for (int i = 0; i < wc; i++) begin
      d = 8'($urandom);
      if (fwd) begin
        exp_q.push_back({fs_pend_m, (i == wc - 1), d});
        fs_pend_m = 1'b0;
      end
      send_byte(1'b0, d);
    end
    send_byte(1'b0, 8'ha5);
    send_byte(1'b0, 8'h5a);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && t < 20000) begin
      @(negedge aclk);
      t++;
    end
    repeat (3) @(negedge aclk);
    n_chk++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    n_chk++;
    if (m_if.tvalid !== 1'b0 || m_if.tuser !== 1'b0 || m_if.tlast !== 1'b0 || m_if.tdata !== 8'h00)
      $display("FAIL reset_m: got v=%b u=%b l=%b d=%h, required all 0",
               m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata);
    else
      n_pass++;
    n_chk++;
    if (frame_start !== 1'b0 || frame_end !== 1'b0 || err_sync !== 1'b0)
      $display("FAIL reset_pulses: got fs=%b fe=%b err=%b, required 0 0 0", frame_start, frame_end, err_sync);
    else
      n_pass++;
    n_chk++;
    if (s_if.tready !== 1'b1)
      $display("FAIL reset_s_tready: got %b, required 1", s_if.tready);
    else
      n_pass++;
  endtask

  task automatic test_latency();
    logic [7:0] d;
    send_hdr(2'd0, 6'h2b, 16'd2);
    d = 8'hc7;
    exp_q.push_back({fs_pend_m, 1'b0, d});
    fs_pend_m = 1'b0;
    send_byte(1'b0, d);
    n_chk++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== d)
      $display("FAIL latency: got v=%b d=%h one cycle after accept, required v=1 d=%h", m_if.tvalid, m_if.tdata, d);
    else
      n_pass++;
    d = 8'h19;
    exp_q.push_back({1'b0, 1'b1, d});
    send_byte(1'b0, d);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h00);
    drain("latency");
  endtask

  task automatic test_frame();
    int fs0, fe0, o0;
    fs0 = fs_cnt; fe0 = fe_cnt; o0 = out_cnt;
    send_short(2'd0, 6'h00);
    @(negedge aclk);
    n_chk++;
    if (frame_start !== 1'b1)
      $display("FAIL fs_timing: got %b the cycle after ECC, required 1", frame_start);
    else
      n_pass++;
    send_long(2'd0, 6'h2b, 10, 1'b1);
    send_short(2'd0, 6'h01);
    drain("frame");
    n_chk++;
    if (fs_cnt - fs0 != 1 || fe_cnt - fe0 != 1)
      $display("FAIL frame_pulses: got fs=%0d fe=%0d, required 1 1", fs_cnt - fs0, fe_cnt - fe0);
    else
      n_pass++;
    n_chk++;
    if (out_cnt - o0 != 10)
      $display("FAIL frame_count: got %0d beats, required 10", out_cnt - o0);
    else
      n_pass++;
  endtask

  task automatic test_two_lines();
    int o0;
    o0 = out_cnt;
    send_short(2'd0, 6'h00);
    send_long(2'd0, 6'h2b, 5, 1'b1);
    send_long(2'd0, 6'h2b, 5, 1'b1);
    send_short(2'd0, 6'h01);
    drain("two_lines");
    n_chk++;
    if (out_cnt - o0 != 10)
      $display("FAIL two_lines_count: got %0d beats, required 10", out_cnt - o0);
    else
      n_pass++;
  endtask

  task automatic test_filter();
    int o0, fs0, fe0, e0;
    o0 = out_cnt; fs0 = fs_cnt; fe0 = fe_cnt; e0 = err_cnt;
    send_byte(1'b0, 8'hff);
    send_byte(1'b0, 8'h00);
    send_long(2'd0, 6'h2a, 20, 1'b0);
    send_long(2'd1, 6'h2b, 20, 1'b0);
    send_short(2'd1, 6'h00);
    send_short(2'd1, 6'h01);
    send_byte(1'b0, 8'h55);
    send_long(2'd0, 6'h2b, 5, 1'b1);
    drain("filter");
    n_chk++;
    if (out_cnt - o0 != 5)
      $display("FAIL filter_count: got %0d beats, required 5", out_cnt - o0);
    else
      n_pass++;
    n_chk++;
    if (fs_cnt != fs0 || fe_cnt != fe0 || err_cnt != e0)
      $display("FAIL filter_pulses: got fs=%0d fe=%0d err=%0d, required 0 0 0",
               fs_cnt - fs0, fe_cnt - fe0, err_cnt - e0);
    else
      n_pass++;
  endtask

  task automatic test_stall();
    int o0;
    o0 = out_cnt;
    ready_mode = 1;
    send_short(2'd0, 6'h00);
    send_long(2'd0, 6'h2b, 1000, 1'b1);
    send_short(2'd0, 6'h01);
    ready_mode = 0;
    drain("stall");
    n_chk++;
    if (out_cnt - o0 != 1000)
      $display("FAIL stall_count: got %0d beats, required 1000", out_cnt - o0);
    else
      n_pass++;
  endtask

  task automatic test_sync();
    int o0, e0;
    logic [7:0] d;
    o0 = out_cnt; e0 = err_cnt;
    send_short(2'd0, 6'h00);
    send_hdr(2'd0, 6'h2b, 16'd10);
    for (int i = 0; i < 3; i++) begin
      d = 8'(8'h70 + i);
      exp_q.push_back({fs_pend_m, 1'b0, d});
      fs_pend_m = 1'b0;
      send_byte(1'b0, d);
    end
    send_long(2'd0, 6'h2b, 5, 1'b1);
    drain("sync");
    n_chk++;
    if (err_cnt - e0 != 1)
      $display("FAIL sync_err: got %0d err_sync pulses, required 1", err_cnt - e0);
    else
      n_pass++;
    n_chk++;
    if (out_cnt - o0 != 8)
      $display("FAIL sync_count: got %0d beats, required 8", out_cnt - o0);
    else
      n_pass++;
  endtask

  task automatic test_fs_fe_empty();
    int o0;
    o0 = out_cnt;
    send_short(2'd0, 6'h00);
    send_short(2'd0, 6'h01);
    n_chk++;
    if (m_if.tvalid !== 1'b0)
      $display("FAIL fs_fe_empty_out: got tvalid=%b, required 0", m_if.tvalid);
    else
      n_pass++;
    send_long(2'd0, 6'h2b, 5, 1'b1);
    drain("fs_fe_empty");
    n_chk++;
    if (out_cnt - o0 != 5)
      $display("FAIL fs_fe_empty_count: got %0d beats, required 5", out_cnt - o0);
    else
      n_pass++;
  endtask

  task automatic test_wc_check();
    int o0, e0;
    o0 = out_cnt; e0 = err_cnt;
`ifdef JELLY2_MIPI_CSI2_RX_CTL_WC_CHECK_EN
    send_long(2'd0, 6'h2b, 7, 1'b0);
    drain("wc_check");
    n_chk++;
    if (out_cnt - o0 != 0 || err_cnt - e0 != 1)
      $display("FAIL wc_check: got %0d beats %0d err, required 0 beats 1 err", out_cnt - o0, err_cnt - e0);
    else
      n_pass++;
`else
    send_long(2'd0, 6'h2b, 7, 1'b1);
    drain("wc_check");
    n_chk++;
    if (out_cnt - o0 != 7 || err_cnt - e0 != 0)
      $display("FAIL wc_check: got %0d beats %0d err, required 7 beats 0 err", out_cnt - o0, err_cnt - e0);
    else
      n_pass++;
`endif
  endtask

  task automatic test_mid_reset();
    int o0;
    ready_mode = 2;
    @(posedge aclk);
    #2;
    send_hdr(2'd0, 6'h2b, 16'd10);
    exp_q.push_back({fs_pend_m, 1'b0, 8'h42});
    send_byte(1'b0, 8'h42);
    #2;
    aresetn = 1'b0;
    #1;
    n_chk++;
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1)
      $display("FAIL mid_reset: got tvalid=%b s_tready=%b, required 0 1", m_if.tvalid, s_if.tready);
    else
      n_pass++;
    exp_q.delete();
    fs_pend_m  = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    o0 = out_cnt;
    send_long(2'd0, 6'h2b, 5, 1'b1);
    drain("mid_reset");
    n_chk++;
    if (out_cnt - o0 != 5)
      $display("FAIL mid_reset_count: got %0d beats, required 5", out_cnt - o0);
    else
      n_pass++;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tdata  = 8'h00;
    m_if.tready = 1'b1;
    fork
      monitor();
      ready_gen();
    join_none
    repeat (3) @(negedge aclk);
    test_reset();
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    test_latency();
    test_frame();
    test_two_lines();
    test_filter();
    test_stall();
    test_sync();
    test_fs_fe_empty();
    test_wc_check();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
